// File: rtl/match_event_logger.sv
// Timestamps serial-pattern match pulses with the bit index that completed them
// and queues the timestamps in a small FIFO drained through valid/ready.
module match_event_logger #(
    parameter int IDX_W = 16,
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     clr,
    input  logic                     match,
    input  logic                     stat_clr,
    output logic                     ev_valid,
    output logic [IDX_W-1:0]         ev_idx,
    input  logic                     ev_ready,
    output logic [CNT_W-1:0]         match_cnt,
    output logic                     ovf,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [IDX_W-1:0] pos_reg;
    logic [IDX_W-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr_reg, wr_ptr_next;
    logic [PW-1:0]    rd_ptr_reg, rd_ptr_next;
    logic [PW-1:0]    level_now;
    logic             ev_valid_reg;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             ovf_reg, ovf_next;
    logic             full, pop, push, drop;

    // Pointers carry one extra bit so full and empty differ at equal addresses.
    always_comb begin
        level_now   = wr_ptr_reg - rd_ptr_reg;
        full        = (level_now == PW'(DEPTH));
        pop         = ev_valid_reg & ev_ready;
        push        = match & (~full | pop);
        drop        = match & full & ~pop;
        wr_ptr_next = wr_ptr_reg + PW'(push);
        rd_ptr_next = rd_ptr_reg + PW'(pop);

        cnt_next = cnt_reg;
        ovf_next = ovf_reg | drop;
        if (stat_clr) begin
            cnt_next = match ? CNT_W'(1) : '0;
            ovf_next = drop;
        end else if (match && (cnt_reg != '1)) begin
            cnt_next = cnt_reg + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            pos_reg      <= '0;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            ev_valid_reg <= 1'b0;
            cnt_reg      <= '0;
            ovf_reg      <= 1'b0;
        end else begin
            pos_reg      <= pos_reg + IDX_W'(1);
            wr_ptr_reg   <= wr_ptr_next;
            rd_ptr_reg   <= rd_ptr_next;
            ev_valid_reg <= (wr_ptr_next != rd_ptr_next);
            cnt_reg      <= cnt_next;
            ovf_reg      <= ovf_next;
        end
    end

    // Storage needs no reset: stale slots are unreachable once pointers clear.
    always_ff @(posedge clk) begin
        if (!clr && push) begin
            mem[wr_ptr_reg[AW-1:0]] <= pos_reg;
        end
    end

    assign ev_valid  = ev_valid_reg;
    assign ev_idx    = ev_valid_reg ? mem[rd_ptr_reg[AW-1:0]] : '0;
    assign match_cnt = cnt_reg;
    assign ovf       = ovf_reg;
    assign level     = level_now;

endmodule

// File: tb/tb_match_event_logger.sv
// Directed scoreboard bench: expected indices queued at push, checked at pop.
module tb_match_event_logger;

    logic        clk = 1'b0;
    logic        clr, match, stat_clr, ev_ready;
    logic        ev_valid;
    logic [15:0] ev_idx;
    logic [7:0]  match_cnt;
    logic        ovf;
    logic [2:0]  level;

    logic        clr2, match2, stat_clr2, ev_ready2;
    logic        ev_valid2;
    logic [3:0]  ev_idx2;
    logic [7:0]  match_cnt2;
    logic        ovf2;
    logic [2:0]  level2;

    int total = 0;
    int bad   = 0;

    int          q[$];
    logic [15:0] m_pos;
    int          m_cnt;
    bit          m_ovf;

    always #5 clk = ~clk;

    match_event_logger #(.IDX_W(16), .DEPTH(4), .CNT_W(8)) dut (
        .clk(clk), .clr(clr), .match(match), .stat_clr(stat_clr),
        .ev_valid(ev_valid), .ev_idx(ev_idx), .ev_ready(ev_ready),
        .match_cnt(match_cnt), .ovf(ovf), .level(level)
    );

    match_event_logger #(.IDX_W(4), .DEPTH(4), .CNT_W(8)) dut_w (
        .clk(clk), .clr(clr2), .match(match2), .stat_clr(stat_clr2),
        .ev_valid(ev_valid2), .ev_idx(ev_idx2), .ev_ready(ev_ready2),
        .match_cnt(match_cnt2), .ovf(ovf2), .level(level2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic do_clr();
        clr = 1'b1; match = 1'b0; stat_clr = 1'b0; ev_ready = 1'b0;
        @(posedge clk); #1;
        clr = 1'b0;
        q.delete();
        m_pos = '0; m_cnt = 0; m_ovf = 1'b0;
        chk("rst_level", 32'(level), 0);
        chk("rst_valid", 32'(ev_valid), 0);
        chk("rst_idx", 32'(ev_idx), 0);
        chk("rst_cnt", 32'(match_cnt), 0);
        chk("rst_ovf", 32'(ovf), 0);
    endtask

    task automatic step(input bit m, input bit r, input bit s);
        bit pop, full, drop;
        int exp;
        match = m; ev_ready = r; stat_clr = s;
        pop  = (q.size() != 0) && r;
        full = (q.size() == 4);
        drop = 1'b0;
        if (pop) begin
            exp = q.pop_front();
            chk("ev_idx_pop", 32'(ev_idx), 32'(exp));
            $display("pop idx=%0d expected=%0d", ev_idx, exp);
        end
        if (m) begin
            if (!full || pop) q.push_back(int'(m_pos));
            else drop = 1'b1;
        end
        if (s) m_cnt = m ? 1 : 0;
        else if (m && m_cnt < 255) m_cnt++;
        if (s) m_ovf = drop;
        else m_ovf = m_ovf | drop;
        m_pos = m_pos + 16'd1;
        @(posedge clk); #1;
        chk("level", 32'(level), 32'(q.size()));
        chk("ev_valid", 32'(ev_valid), 32'(q.size() != 0));
        chk("match_cnt", 32'(match_cnt), 32'(m_cnt));
        chk("ovf", 32'(ovf), 32'(m_ovf));
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        clr = 1'b1; match = 1'b0; stat_clr = 1'b0; ev_ready = 1'b0;
        clr2 = 1'b1; match2 = 1'b0; stat_clr2 = 1'b0; ev_ready2 = 1'b0;
        @(posedge clk); #1;

        // Detector stream 1,1,0,1,1,0,1: matches at cycles 3 and 6
        do_clr();
        for (int c = 0; c < 7; c++) step(c == 3 || c == 6, 1'b0, 1'b0);
        chk("t1_level", 32'(level), 2);
        chk("t1_cnt", 32'(match_cnt), 2);
        chk("t1_head", 32'(ev_idx), 3);
        drain(3);

        // Fill to DEPTH then overflow on the fifth match
        do_clr();
        for (int c = 0; c < 10; c++) step(c % 2 == 0 && c <= 8, 1'b0, 1'b0);
        chk("t2_ovf", 32'(ovf), 1);
        chk("t2_cnt", 32'(match_cnt), 5);
        chk("t2_level", 32'(level), 4);
        drain(5);

        // Full FIFO with simultaneous push and pop at cycle 20
        do_clr();
        for (int c = 0; c < 20; c++) step(c < 4, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        chk("t3_level", 32'(level), 4);
        chk("t3_ovf", 32'(ovf), 0);
        drain(5);

        // Counter saturation and stat_clr with a coincident match
        do_clr();
        for (int c = 0; c < 300; c++) step(1'b1, 1'b1, 1'b0);
        chk("t4_sat", 32'(match_cnt), 255);
        step(1'b1, 1'b1, 1'b1);
        chk("t4_statclr", 32'(match_cnt), 1);
        drain(3);

        // Reset mid-operation with level=3 and ovf=1
        do_clr();
        for (int c = 0; c < 5; c++) step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        chk("t5_level", 32'(level), 3);
        chk("t5_ovf", 32'(ovf), 1);
        do_clr();
        step(1'b1, 1'b0, 1'b0);
        chk("t5_idx0", 32'(ev_idx), 0);
        drain(2);

        // Index wrap on the 4-bit instance: cycles 15 and 16 log 15 then 0
        clr2 = 1'b0;
        for (int c = 0; c < 18; c++) begin
            match2 = (c == 15 || c == 16);
            @(posedge clk); #1;
        end
        match2 = 1'b0;
        chk("wrap_level", 32'(level2), 2);
        chk("wrap_first", 32'(ev_idx2), 15);
        $display("wrap head idx=%0d", ev_idx2);
        ev_ready2 = 1'b1;
        @(posedge clk); #1;
        chk("wrap_second", 32'(ev_idx2), 0);
        $display("wrap head idx=%0d", ev_idx2);
        @(posedge clk); #1;
        chk("wrap_empty", 32'(ev_valid2), 0);
        ev_ready2 = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/match_event_logger.md
Name: match_event_logger

Overview:
- Sits directly downstream of the serial 1101 pattern detector. Consumes the detector's one-cycle match pulse, which is sampled on the same clock edge as the serial bit that completes the pattern.
- Timestamps each match with the index of the bit that completed it and buffers the timestamps in a small FIFO. A consumer drains the FIFO through a valid/ready handshake.
- Also keeps a saturating total-match counter and a sticky overflow flag for status readout.

Parameters:
- IDX_W, 16, width of the bit-position counter and of each logged index.
- DEPTH, 4, number of FIFO entries. Must be a power of two, at least 2.
- CNT_W, 8, width of the saturating match counter.

Ports:
- clk  input  1  single system clock; all state updates on its rising edge.
- clr  input  1  synchronous, active-high reset.
- match  input  1  detector output; high for one cycle when 1101 completes on the current bit.
- stat_clr  input  1  synchronous clear of match_cnt and ovf only.
- ev_valid  output  1  head FIFO entry is available.
- ev_idx  output  IDX_W  bit index of head entry; valid only when ev_valid=1.
- ev_ready  input  1  consumer accepts head entry.
- match_cnt  output  CNT_W  total matches since reset/stat_clr, saturating.
- ovf  output  1  sticky: a match was dropped because the FIFO was full.
- level  output  clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (clr=1 at a rising edge): pos=0, FIFO empty, ev_valid=0, ev_idx=0, match_cnt=0, ovf=0, level=0. clr overrides every other input.
- A reset asserted mid-operation discards all buffered entries and restarts bit indexing at 0 on the first cycle after clr deasserts.
- Bit position: pos is an internal IDX_W counter. It equals 0 on the first cycle after reset and increments by 1 every clock. It wraps from 2^IDX_W-1 to 0 without a flag.
- Logged index: a match sampled at an edge logs the pos value of that same cycle, i.e. the index of the bit that completed the pattern.
- Push: a push is attempted when match=1.
  - If level<DEPTH, or a pop occurs in the same cycle, the entry is written.
  - Otherwise the entry is dropped and ovf is set to 1.
- Pop: a pop occurs when ev_valid=1 and ev_ready=1. The head advances on that edge.
- ev_valid is registered and equals (level!=0). There is no bypass: a push into an empty FIFO makes ev_valid=1 one cycle later, so minimum match-to-ev_valid latency is 1 cycle.
- ev_idx is stable while ev_valid=1 and ev_ready=0. The consumer may hold ev_ready high continuously.
- Push and pop in the same cycle:
  - Always legal; level is unchanged.
  - When full, the pop frees a slot and the push is accepted, so no drop and no ovf.
  - When empty, only the push takes effect (ev_valid is still 0).
- Order is strictly FIFO. Read/write pointers wrap modulo DEPTH, using an extra pointer bit to distinguish full from empty.
- match_cnt: increments by 1 on each match, whether accepted or dropped. It holds at 2^CNT_W-1 (saturates, no wrap).
- stat_clr:
  - Next match_cnt = match ? 1 : 0.
  - Next ovf = 1 only if a drop occurs in the same cycle, else 0.
  - FIFO contents and pos are unaffected.
- ovf stays 1 until clr or stat_clr.
- All outputs are registered or direct decodes of registers; none is combinational from inputs.

Test Plan:
- Reset, then drive match=1 at cycles 3 and 6 (the detector pulses for serial stream 1,1,0,1,1,0,1) with ev_ready=0 -> level=2, ev_valid=1 from cycle 4, entries 3 then 6, match_cnt=2, ovf=0.
- DEPTH=4, ev_ready=0, match at cycles 0,2,4,6,8 -> level=4 after cycle 6; match at cycle 8 dropped; ovf=1 from cycle 9; match_cnt=5; drained order 0,2,4,6.
- FIFO full (4 entries), ev_ready=1 and match=1 at cycle 20 -> head popped, 20 pushed, level stays 4, ovf stays 0, tail entry=20.
- match held high for 300 cycles with CNT_W=8, ev_ready=1 -> match_cnt saturates at 255; stat_clr with match=1 -> match_cnt=1 next cycle.
- IDX_W=4, match at cycle 15 and cycle 16 -> logged indices 15 then 0 (wrap).
- Assert clr for 1 cycle while level=3 and ovf=1 -> next cycle level=0, ev_valid=0, match_cnt=0, ovf=0; a subsequent match logs index 0 or its cycle offset from reset.
